// File: rtl/fetch_defs.sv
// Shared definitions for the fetch-side WEX bundler: opcode prefixes,
// halfword length codes and queue geometry.
package fetch_defs;

    localparam logic [7:0] OpE0 = 8'hE0;
    localparam logic [7:0] OpEC = 8'hEC;
    localparam logic [7:0] OpF0 = 8'hF0;
    localparam logic [7:0] OpF8 = 8'hF8;
    localparam logic [7:0] OpFC = 8'hFC;

    typedef enum logic [1:0] {
        LenH1 = 2'd1,
        LenH2 = 2'd2,
        LenH3 = 2'd3
    } hwLen_t;

    localparam int unsigned QueueDepth = 8;
    localparam int unsigned HwWidth    = 16;

endpackage

// File: rtl/fetch_wex_bundler_if.sv
// Fetch/redirect/decode signal bundle around the bundler; master is the bundler side.
interface fetch_wex_bundler_if #(
    parameter int unsigned PC_WIDTH = 48
) ();
    logic                srWxe;
    logic                flushValid;
    logic [PC_WIDTH-1:0] flushPc;
    logic                ifValid;
    logic                ifReady;
    logic [63:0]         ifBlock;
    logic [1:0]          ifSkip;
    logic                outValid;
    logic                outReady;
    logic [95:0]         istrWord;
    logic [2:0]          outLen;
    logic [PC_WIDTH-1:0] outPc;
    logic                outWexErr;

    modport master (
        input  srWxe, flushValid, flushPc, ifValid, ifBlock, ifSkip, outReady,
        output ifReady, outValid, istrWord, outLen, outPc, outWexErr
    );

    modport slave (
        output srWxe, flushValid, flushPc, ifValid, ifBlock, ifSkip, outReady,
        input  ifReady, outValid, istrWord, outLen, outPc, outWexErr
    );
endinterface

// File: rtl/fetch_op_len.sv
// Classifies one leading halfword: op length in halfwords, 32-bit-op flag and
// the effective WEX chaining flag.
module fetch_op_len
    import fetch_defs::*;
(
    input  logic [15:0] halfword,
    input  logic        srWxe,
    output hwLen_t      lenCode,
    output logic        isOp32,
    output logic        wexFlag
);
    logic [7:0] prefix;

    assign prefix = halfword[15:8];

    always_comb begin
        lenCode = LenH1;
        isOp32  = 1'b0;
        wexFlag = 1'b0;
        if ((prefix >= OpE0 && prefix < OpEC) || (prefix >= OpF0 && prefix < OpFC)) begin
            lenCode = LenH2;
            isOp32  = 1'b1;
        end else if (prefix >= OpEC) begin
            lenCode = LenH3;
        end
        // Only F-forms chain; E-forms are predicated and never do.
        if (prefix >= OpF0 && prefix < OpF8) begin
            wexFlag = srWxe & halfword[10];
        end else if (prefix >= OpF8 && prefix < OpFC) begin
            wexFlag = srWxe & halfword[8];
        end
    end
endmodule

// File: rtl/fetch_wex_bundler.sv
// Buffers fetch blocks in an 8-halfword shift queue and presents the next
// instruction or WEX bundle, left-aligned, to decode.
module fetch_wex_bundler
    import fetch_defs::*;
#(
    parameter int unsigned PC_WIDTH = 48
) (
    input logic                 clock,
    input logic                 reset,
    fetch_wex_bundler_if.master bus
);
    localparam int unsigned QueueBits = QueueDepth * HwWidth;

    logic [QueueBits-1:0] queueQ, queueD;
    logic [3:0]           countQ, countD;
    logic [PC_WIDTH-1:0]  pcQ, pcD;

    hwLen_t len0, len1, len2;
    logic   op32First, op32Second, op32Third;
    logic   wex0, wex1, wex2;
    logic   unusedOpInfo;

    logic [2:0]  bundleLen;
    logic        wexErr;
    logic        outValid;
    logic [95:0] wordMask;
    logic [2:0]  popLen;
    logic [2:0]  pushLen;
    logic [3:0]  keepCount;
    logic [63:0] pushData;

    fetch_op_len u_opLen0 (
        .halfword (queueQ[15:0]),
        .srWxe    (bus.srWxe),
        .lenCode  (len0),
        .isOp32   (op32First),
        .wexFlag  (wex0)
    );

    fetch_op_len u_opLen1 (
        .halfword (queueQ[47:32]),
        .srWxe    (bus.srWxe),
        .lenCode  (len1),
        .isOp32   (op32Second),
        .wexFlag  (wex1)
    );

    fetch_op_len u_opLen2 (
        .halfword (queueQ[79:64]),
        .srWxe    (bus.srWxe),
        .lenCode  (len2),
        .isOp32   (op32Third),
        .wexFlag  (wex2)
    );

    // A WEX flag on the third op is ignored; lengths beyond op0 follow from isOp32.
    assign unusedOpInfo = ^{len1, len2, wex2};

    // Undecided chains report the smallest length still possible so that
    // outValid stays low until the deciding halfword has arrived.
    always_comb begin
        bundleLen = 3'd1;
        wexErr    = 1'b0;
        case (len0)
            LenH1: bundleLen = 3'd1;
            LenH3: bundleLen = 3'd3;
            default: begin
                if (!wex0 || !op32First) begin
                    bundleLen = 3'd2;
                end else if (countQ < 4'd3) begin
                    bundleLen = 3'd4;
                end else if (!op32Second) begin
                    bundleLen = 3'd2;
                    wexErr    = 1'b1;
                end else if (!wex1) begin
                    bundleLen = 3'd4;
                end else if (countQ < 4'd5) begin
                    bundleLen = 3'd6;
                end else if (!op32Third) begin
                    bundleLen = 3'd4;
                    wexErr    = 1'b1;
                end else begin
                    bundleLen = 3'd6;
                end
            end
        endcase
    end

    always_comb begin
        wordMask = '0;
        for (int k = 0; k < 6; k++) begin
            if (k < int'(bundleLen)) begin
                wordMask[HwWidth*k +: HwWidth] = '1;
            end
        end
    end

    assign outValid      = (countQ >= {1'b0, bundleLen});
    assign bus.outValid  = outValid;
    assign bus.outLen    = bundleLen;
    assign bus.outWexErr = wexErr;
    assign bus.istrWord  = queueQ[95:0] & wordMask;
    assign bus.outPc     = pcQ;
    assign bus.ifReady   = (countQ <= 4'd4);

    assign popLen    = (outValid && bus.outReady) ? bundleLen : 3'd0;
    assign pushLen   = (bus.ifValid && bus.ifReady) ? (3'd4 - {1'b0, bus.ifSkip}) : 3'd0;
    assign keepCount = countQ - {1'b0, popLen};
    assign pushData  = bus.ifBlock >> {bus.ifSkip, 4'b0};

    always_comb begin
        queueD = queueQ >> {popLen, 4'b0};
        countD = keepCount + {1'b0, pushLen};
        pcD    = pcQ + {{(PC_WIDTH-4){1'b0}}, popLen, 1'b0};
        if (pushLen != 3'd0) begin
            queueD = queueD | ({64'h0, pushData} << {keepCount, 4'b0});
        end
        if (bus.flushValid) begin
            queueD = '0;
            countD = '0;
            pcD    = bus.flushPc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            queueQ <= '0;
            countQ <= '0;
            pcQ    <= '0;
        end else begin
            queueQ <= queueD;
            countQ <= countD;
            pcQ    <= pcD;
        end
    end
endmodule
